raizing_extratext_writer: RTL and testbench

- CPU-side writer/responder for the extra-text layer memories: text VRAM (4096 words), line-select RAM (256 words) and line-scroll RAM (256 words).
- Decodes 68k word accesses into byte-enabled writes and read-backs on the write port of each dual-port RAM. The line renderer reads the other port.
- Provides DTACK handshaking and a post-reset clear engine that zeroes all three memories before any CPU access is served.

---
 rtl/raizing_extratext_writer.sv | 203 ++++++++++++++++++++
 tb/tb_raizing_extratext_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_extratext_writer.sv
// CPU-side writer/responder for the extra-text layer memories (text VRAM,
// line-select RAM, line-scroll RAM). Turns 68k word accesses into byte-enabled
// writes or read-backs on each RAM's CPU port, answers with DTACK, and zeroes
// all three RAMs after reset before serving the CPU.
//
// Ports:
//   CLK, RESET_N            clock / async active-low reset
//   CPU_CS, CPU_RNW         chip select (held for the bus cycle), 1 = read
//   CPU_ADDR[12:0]          word address inside the text region
//   CPU_UDS_N, CPU_LDS_N    byte strobes, active low
//   CPU_DIN, CPU_DOUT       CPU write data / read data
//   CPU_DTACK_N             data acknowledge, active low
//   TVRAM_ADDR/WE/Q         text VRAM port (4096 words)
//   SEL_ADDR/WE/Q           line-select RAM port (256 words)
//   SCR_ADDR/WE/Q           line-scroll RAM port (256 words)
//   RAM_WDATA               write data shared by all three RAMs
//   CLEAR_BUSY              high while the post-reset clear sweep runs
module raizing_extratext_writer #(
  parameter int unsigned RD_LAT         = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CPU_CS,
  input  logic        CPU_RNW,
  input  logic [12:0] CPU_ADDR,
  input  logic        CPU_UDS_N,
  input  logic        CPU_LDS_N,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACK_N,
  output logic [11:0] TVRAM_ADDR,
  output logic [1:0]  TVRAM_WE,
  input  logic [15:0] TVRAM_Q,
  output logic [7:0]  SEL_ADDR,
  output logic [1:0]  SEL_WE,
  input  logic [15:0] SEL_Q,
  output logic [7:0]  SCR_ADDR,
  output logic [1:0]  SCR_WE,
  input  logic [15:0] SCR_Q,
  output logic [15:0] RAM_WDATA,
  output logic        CLEAR_BUSY
);

  localparam logic [12:0] CLR_LAST = 13'h11FF;
  localparam logic [1:0]  RD_WAIT  = 2'(RD_LAT);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_READ, S_ACK} state_t;
  typedef enum logic [1:0] {T_TV, T_SEL, T_SCR, T_NONE} tgt_t;

  // Region decode of a word address
  function automatic tgt_t decode(input logic [12:0] a);
    if (!a[12])                 return T_TV;
    else if (a[11:8] == 4'h0)   return T_SEL;
    else if (a[11:8] == 4'h1)   return T_SCR;
    else                        return T_NONE;
  endfunction

  state_t      state, state_nxt;
  logic [12:0] clr_cnt, clr_nxt;
  logic [1:0]  rd_cnt, rd_nxt;
  logic [12:0] lat_addr, addr_nxt;
  logic [1:0]  lat_be, be_nxt;
  logic [15:0] lat_din, din_nxt;
  logic [11:0] tv_addr_nxt;
  logic [7:0]  sel_addr_nxt, scr_addr_nxt;
  logic [1:0]  tv_we_nxt, sel_we_nxt, scr_we_nxt;
  logic [15:0] wdata_nxt, dout_nxt;
  logic        dtack_nxt, busy_nxt;

  // State, latches and all outputs are registered
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt     <= '0;
      rd_cnt      <= '0;
      lat_addr    <= '0;
      lat_be      <= '0;
      lat_din     <= '0;
      TVRAM_ADDR  <= '0;
      SEL_ADDR    <= '0;
      SCR_ADDR    <= '0;
      TVRAM_WE    <= '0;
      SEL_WE      <= '0;
      SCR_WE      <= '0;
      RAM_WDATA   <= '0;
      CPU_DOUT    <= '0;
      CPU_DTACK_N <= 1'b1;
      CLEAR_BUSY  <= CLEAR_ON_RESET;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_nxt;
      rd_cnt      <= rd_nxt;
      lat_addr    <= addr_nxt;
      lat_be      <= be_nxt;
      lat_din     <= din_nxt;
      TVRAM_ADDR  <= tv_addr_nxt;
      SEL_ADDR    <= sel_addr_nxt;
      SCR_ADDR    <= scr_addr_nxt;
      TVRAM_WE    <= tv_we_nxt;
      SEL_WE      <= sel_we_nxt;
      SCR_WE      <= scr_we_nxt;
      RAM_WDATA   <= wdata_nxt;
      CPU_DOUT    <= dout_nxt;
      CPU_DTACK_N <= dtack_nxt;
      CLEAR_BUSY  <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    clr_nxt      = clr_cnt;
    rd_nxt       = rd_cnt;
    addr_nxt     = lat_addr;
    be_nxt       = lat_be;
    din_nxt      = lat_din;
    tv_addr_nxt  = TVRAM_ADDR;
    sel_addr_nxt = SEL_ADDR;
    scr_addr_nxt = SCR_ADDR;
    tv_we_nxt    = '0;
    sel_we_nxt   = '0;
    scr_we_nxt   = '0;
    wdata_nxt    = RAM_WDATA;
    dout_nxt     = CPU_DOUT;
    dtack_nxt    = 1'b1;
    busy_nxt     = 1'b0;

    unique case (state)
      S_CLEAR: begin
        // One zero word per cycle across TVRAM, SEL, SCR in address order
        busy_nxt  = 1'b1;
        wdata_nxt = '0;
        unique case (decode(clr_cnt))
          T_TV:    begin tv_we_nxt  = 2'b11; tv_addr_nxt  = clr_cnt[11:0]; end
          T_SEL:   begin sel_we_nxt = 2'b11; sel_addr_nxt = clr_cnt[7:0];  end
          T_SCR:   begin scr_we_nxt = 2'b11; scr_addr_nxt = clr_cnt[7:0];  end
          default: ;
        endcase
        if (clr_cnt == CLR_LAST) begin
          clr_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          clr_nxt = clr_cnt + 13'd1;
        end
      end

      S_IDLE: begin
        if (CPU_CS && !(CPU_UDS_N && CPU_LDS_N)) begin
          addr_nxt  = CPU_ADDR;
          be_nxt    = {~CPU_UDS_N, ~CPU_LDS_N};
          din_nxt   = CPU_DIN;
          rd_nxt    = '0;
          state_nxt = CPU_RNW ? S_READ : S_WRITE;
        end
      end

      S_WRITE: begin
        wdata_nxt = lat_din;
        unique case (decode(lat_addr))
          T_TV:    begin tv_we_nxt  = lat_be; tv_addr_nxt  = lat_addr[11:0]; end
          T_SEL:   begin sel_we_nxt = lat_be; sel_addr_nxt = lat_addr[7:0];  end
          T_SCR:   begin scr_we_nxt = lat_be; scr_addr_nxt = lat_addr[7:0];  end
          default: ;
        endcase
        // An access abandoned by the CPU completes silently
        dtack_nxt = ~CPU_CS;
        state_nxt = S_ACK;
      end

      S_READ: begin
        unique case (decode(lat_addr))
          T_TV:    tv_addr_nxt  = lat_addr[11:0];
          T_SEL:   sel_addr_nxt = lat_addr[7:0];
          T_SCR:   scr_addr_nxt = lat_addr[7:0];
          default: ;
        endcase
        // Address is on the RAM port from the first READ edge; Q is valid RD_LAT cycles later
        if (rd_cnt == RD_WAIT) begin
          unique case (decode(lat_addr))
            T_TV:    dout_nxt = TVRAM_Q;
            T_SEL:   dout_nxt = SEL_Q;
            T_SCR:   dout_nxt = SCR_Q;
            default: dout_nxt = 16'hFFFF;
          endcase
          dtack_nxt = ~CPU_CS;
          state_nxt = S_ACK;
        end else begin
          rd_nxt = rd_cnt + 2'd1;
        end
      end

      S_ACK: begin
        // Hold DTACK until CS drops so a long CS gives only one access
        if (CPU_CS) dtack_nxt = 1'b0;
        else        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_raizing_extratext_writer.sv
module tb_raizing_extratext_writer;

  localparam int RDL = 2;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CPU_CS = 1'b0, CPU_RNW = 1'b1, CPU_UDS_N = 1'b1, CPU_LDS_N = 1'b1;
  logic [12:0] CPU_ADDR = '0;
  logic [15:0] CPU_DIN = '0;
  logic [15:0] CPU_DOUT;
  logic        CPU_DTACK_N;
  logic [11:0] TVRAM_ADDR;
  logic [7:0]  SEL_ADDR, SCR_ADDR;
  logic [1:0]  TVRAM_WE, SEL_WE, SCR_WE;
  logic [15:0] TVRAM_Q, SEL_Q, SCR_Q, RAM_WDATA;
  logic        CLEAR_BUSY;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  raizing_extratext_writer #(.RD_LAT(RDL), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CPU_CS(CPU_CS), .CPU_RNW(CPU_RNW),
    .CPU_ADDR(CPU_ADDR), .CPU_UDS_N(CPU_UDS_N), .CPU_LDS_N(CPU_LDS_N),
    .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_DTACK_N(CPU_DTACK_N),
    .TVRAM_ADDR(TVRAM_ADDR), .TVRAM_WE(TVRAM_WE), .TVRAM_Q(TVRAM_Q),
    .SEL_ADDR(SEL_ADDR), .SEL_WE(SEL_WE), .SEL_Q(SEL_Q),
    .SCR_ADDR(SCR_ADDR), .SCR_WE(SCR_WE), .SCR_Q(SCR_Q),
    .RAM_WDATA(RAM_WDATA), .CLEAR_BUSY(CLEAR_BUSY)
  );

  // RAM models: byte-write port, registered read
  logic [15:0] tv_mem [4096];
  logic [15:0] sel_mem [256];
  logic [15:0] scr_mem [256];
  logic fill = 1'b0, poke = 1'b0;

  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) tv_mem[i] <= 16'h5A5A;
      for (int i = 0; i < 256; i++) begin sel_mem[i] <= 16'h5A5A; scr_mem[i] <= 16'h5A5A; end
    end else begin
      if (poke) sel_mem[8'h10] <= 16'h00C7;
      if (TVRAM_WE[1]) tv_mem[TVRAM_ADDR][15:8] <= RAM_WDATA[15:8];
      if (TVRAM_WE[0]) tv_mem[TVRAM_ADDR][7:0]  <= RAM_WDATA[7:0];
      if (SEL_WE[1])   sel_mem[SEL_ADDR][15:8]  <= RAM_WDATA[15:8];
      if (SEL_WE[0])   sel_mem[SEL_ADDR][7:0]   <= RAM_WDATA[7:0];
      if (SCR_WE[1])   scr_mem[SCR_ADDR][15:8]  <= RAM_WDATA[15:8];
      if (SCR_WE[0])   scr_mem[SCR_ADDR][7:0]   <= RAM_WDATA[7:0];
    end
    TVRAM_Q <= tv_mem[TVRAM_ADDR];
    SEL_Q   <= sel_mem[SEL_ADDR];
    SCR_Q   <= scr_mem[SCR_ADDR];
  end

  // Clear-sweep monitor: sample index k is the k-th cycle after reset release
  logic mon_en = 1'b0;
  int mon_idx = 0, busy_n = 0, bad = 0;
  int tv_n = 0, tv_first = -1, tv_last = -1;
  int sel_n = 0, sel_first = -1, sel_last = -1;
  int scr_n = 0, scr_first = -1, scr_last = -1;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (CLEAR_BUSY) busy_n++;
      if (TVRAM_WE != 2'b00) begin
        if (tv_n == 0) tv_first = mon_idx;
        tv_last = mon_idx; tv_n++;
        if (TVRAM_WE != 2'b11 || 32'(TVRAM_ADDR) != (mon_idx & 32'hFFF) || RAM_WDATA != 0) bad++;
      end
      if (SEL_WE != 2'b00) begin
        if (sel_n == 0) sel_first = mon_idx;
        sel_last = mon_idx; sel_n++;
        if (SEL_WE != 2'b11 || 32'(SEL_ADDR) != (mon_idx & 32'hFF) || RAM_WDATA != 0) bad++;
      end
      if (SCR_WE != 2'b00) begin
        if (scr_n == 0) scr_first = mon_idx;
        scr_last = mon_idx; scr_n++;
        if (SCR_WE != 2'b11 || 32'(SCR_ADDR) != (mon_idx & 32'hFF) || RAM_WDATA != 0) bad++;
      end
      mon_idx++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Results of one bus access
  int r_lat, r_we_cnt;
  logic r_held, r_rel;
  logic [1:0] r_tv, r_sel, r_scr;
  logic [11:0] r_idx;
  logic [15:0] r_wd, r_dout;

  task automatic do_access(input logic [12:0] a, input logic rnw, input logic [1:0] be_n,
                           input logic [15:0] din);
    @(negedge CLK);
    CPU_ADDR = a; CPU_RNW = rnw; {CPU_UDS_N, CPU_LDS_N} = be_n; CPU_DIN = din; CPU_CS = 1'b1;
    r_lat = -1; r_we_cnt = 0; r_tv = '0; r_sel = '0; r_scr = '0; r_idx = '0; r_wd = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if ((TVRAM_WE | SEL_WE | SCR_WE) != 2'b00) begin
        r_we_cnt++; r_tv = TVRAM_WE; r_sel = SEL_WE; r_scr = SCR_WE; r_wd = RAM_WDATA;
        r_idx = (TVRAM_WE != 0) ? TVRAM_ADDR : (SEL_WE != 0) ? {4'h0, SEL_ADDR} : {4'h0, SCR_ADDR};
      end
      if (!CPU_DTACK_N && r_lat < 0) r_lat = k;
    end
    r_held = ~CPU_DTACK_N;
    r_dout = CPU_DOUT;
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    @(negedge CLK);
    r_rel = CPU_DTACK_N;
    if ((TVRAM_WE | SEL_WE | SCR_WE) != 2'b00) r_we_cnt++;
  endtask

  typedef struct {
    logic [12:0] addr; logic rnw; logic [1:0] be_n; logic [15:0] din;
    int lat; logic [15:0] dout; logic [1:0] tv; logic [1:0] sel; logic [1:0] scr; logic [11:0] idx;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int nz, early, got;
    vecs[0]  = '{13'h0ABC, 1'b0, 2'b00, 16'h1234, 2,     16'h0000, 2'b11, 2'b00, 2'b00, 12'hABC};
    vecs[1]  = '{13'h1105, 1'b0, 2'b01, 16'hBEEF, 2,     16'h0000, 2'b00, 2'b00, 2'b10, 12'h005};
    vecs[2]  = '{13'h1105, 1'b1, 2'b00, 16'h0000, RDL+2, 16'hBE00, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[3]  = '{13'h1010, 1'b1, 2'b00, 16'h0000, RDL+2, 16'h00C7, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[4]  = '{13'h1800, 1'b1, 2'b00, 16'h0000, RDL+2, 16'hFFFF, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[5]  = '{13'h1800, 1'b0, 2'b00, 16'h5555, 2,     16'h0000, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[6]  = '{13'h1010, 1'b0, 2'b10, 16'h3344, 2,     16'h0000, 2'b00, 2'b01, 2'b00, 12'h010};
    vecs[7]  = '{13'h1010, 1'b1, 2'b00, 16'h0000, RDL+2, 16'h0044, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[8]  = '{13'h0ABC, 1'b1, 2'b00, 16'h0000, RDL+2, 16'h1234, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[9]  = '{13'h0FFF, 1'b1, 2'b00, 16'h0000, RDL+2, 16'h0000, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[10] = '{13'h10FF, 1'b0, 2'b00, 16'hABCD, 2,     16'h0000, 2'b00, 2'b11, 2'b00, 12'h0FF};
    vecs[11] = '{13'h10FF, 1'b1, 2'b00, 16'h0000, RDL+2, 16'hABCD, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[12] = '{13'h11FF, 1'b0, 2'b00, 16'h7777, 2,     16'h0000, 2'b00, 2'b00, 2'b11, 12'h0FF};
    vecs[13] = '{13'h11FF, 1'b1, 2'b00, 16'h0000, RDL+2, 16'h7777, 2'b00, 2'b00, 2'b00, 12'h000};
    vecs[14] = '{13'h1200, 1'b1, 2'b00, 16'h0000, RDL+2, 16'hFFFF, 2'b00, 2'b00, 2'b00, 12'h000};

    // Reset with RAMs preloaded to 0x5A5A
    fill = 1'b1;
    repeat (3) @(negedge CLK);
    fill = 1'b0;
    chk("rst_dtack", 32'(CPU_DTACK_N), 1);
    chk("rst_busy", 32'(CLEAR_BUSY), 1);
    chk("rst_we", 32'({TVRAM_WE, SEL_WE, SCR_WE}), 0);
    chk("rst_addr", 32'({TVRAM_ADDR, SEL_ADDR, SCR_ADDR}), 0);
    chk("rst_data", 32'({CPU_DOUT, RAM_WDATA}), 0);
    chk("preload", 32'(tv_mem[12'h123]), 32'h5A5A);

    // Post-reset clear sweep
    @(negedge CLK); #1;
    RESET_N = 1'b1;
    mon_en = 1'b1;
    got = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (!CLEAR_BUSY) begin got = 1; break; end
    end
    mon_en = 1'b0;
    chk("clear_done", 32'(got), 1);
    chk("clear_busy_cycles", 32'(busy_n), 4608);
    chk("clear_tv_n", 32'(tv_n), 4096);
    chk("clear_tv_win", 32'({tv_first[15:0], tv_last[15:0]}), {16'd0, 16'd4095});
    chk("clear_sel_n", 32'(sel_n), 256);
    chk("clear_sel_win", 32'({sel_first[15:0], sel_last[15:0]}), {16'd4096, 16'd4351});
    chk("clear_scr_n", 32'(scr_n), 256);
    chk("clear_scr_win", 32'({scr_first[15:0], scr_last[15:0]}), {16'd4352, 16'd4607});
    chk("clear_addr_data", 32'(bad), 0);
    @(negedge CLK);
    nz = 0;
    for (int i = 0; i < 4096; i++) if (tv_mem[i] != 0) nz++;
    for (int i = 0; i < 256; i++) begin if (sel_mem[i] != 0) nz++; if (scr_mem[i] != 0) nz++; end
    chk("clear_zero", 32'(nz), 0);

    // Plant the SEL read-back value
    poke = 1'b1; @(negedge CLK); poke = 1'b0;

    // Table-driven accesses
    for (int v = 0; v < 15; v++) begin
      do_access(vecs[v].addr, vecs[v].rnw, vecs[v].be_n, vecs[v].din);
      chk($sformatf("v%0d_lat", v), 32'(r_lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_held", v), 32'(r_held), 1);
      chk($sformatf("v%0d_release", v), 32'(r_rel), 1);
      chk($sformatf("v%0d_we", v), 32'({r_tv, r_sel, r_scr}),
          32'({vecs[v].tv, vecs[v].sel, vecs[v].scr}));
      chk($sformatf("v%0d_we_cnt", v), 32'(r_we_cnt),
          ((vecs[v].tv | vecs[v].sel | vecs[v].scr) != 0) ? 1 : 0);
      if ((vecs[v].tv | vecs[v].sel | vecs[v].scr) != 0) begin
        chk($sformatf("v%0d_idx", v), 32'(r_idx), 32'(vecs[v].idx));
        chk($sformatf("v%0d_wdata", v), 32'(r_wd), 32'(vecs[v].din));
      end
      if (vecs[v].rnw) chk($sformatf("v%0d_dout", v), 32'(r_dout), 32'(vecs[v].dout));
    end

    // Both strobes high: never accepted
    @(negedge CLK);
    CPU_ADDR = 13'h0100; CPU_RNW = 1'b0; CPU_DIN = 16'h1111; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    CPU_CS = 1'b1;
    early = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (!CPU_DTACK_N) early++;
      if ((TVRAM_WE | SEL_WE | SCR_WE) != 0) got++;
    end
    CPU_CS = 1'b0;
    chk("nostrobe_dtack", 32'(early), 0);
    chk("nostrobe_we", 32'(got), 0);

    // CS dropped before ACK: write still lands, no DTACK
    @(negedge CLK);
    CPU_ADDR = 13'h0200; CPU_RNW = 1'b0; CPU_DIN = 16'hCAFE; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    CPU_CS = 1'b1;
    @(negedge CLK);
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    early = 0; got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (!CPU_DTACK_N) early++;
      if (TVRAM_WE == 2'b11 && TVRAM_ADDR == 12'h200) got++;
    end
    chk("abort_dtack", 32'(early), 0);
    chk("abort_we", 32'(got), 1);
    do_access(13'h0200, 1'b1, 2'b00, 16'h0000);
    chk("abort_readback", 32'(r_dout), 32'hCAFE);

    // Reset mid-write: WE drops asynchronously, sweep restarts at 0
    @(negedge CLK);
    CPU_ADDR = 13'h0300; CPU_RNW = 1'b0; CPU_DIN = 16'h9999; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    CPU_CS = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (TVRAM_WE != 0) begin got = 1; break; end
    end
    chk("midwrite_we_seen", 32'(got), 1);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_we_off", 32'({TVRAM_WE, SEL_WE, SCR_WE}), 0);
    chk("async_busy", 32'(CLEAR_BUSY), 1);
    chk("async_addr", 32'(TVRAM_ADDR), 0);
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    @(negedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("restart_c0", 32'({TVRAM_WE, 4'h0, TVRAM_ADDR}), 32'({2'b11, 4'h0, 12'h000}));
    repeat (100) @(negedge CLK);
    chk("restart_c100", 32'(TVRAM_ADDR), 100);

    // CS during clear: stalled until the sweep ends, then served
    CPU_ADDR = 13'h1105; CPU_RNW = 1'b1; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0; CPU_CS = 1'b1;
    early = 0; got = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (!CPU_DTACK_N && CLEAR_BUSY) early++;
      if (!CPU_DTACK_N) begin got = 1; break; end
    end
    chk("stall_no_early_dtack", 32'(early), 0);
    chk("stall_served", 32'(got), 1);
    chk("stall_dout", 32'(CPU_DOUT), 0);
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    @(negedge CLK);
    chk("stall_release", 32'(CPU_DTACK_N), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
